parity_stream_unit: RTL
=======================

// Module: parity_stream_unit
// PURPOSE
// - Parametrised, registered parity generator/checker for the UART TX/RX datapath.
// - Streams words through a valid/ready handshake with 1-cycle latency.
// - Generate mode appends a parity bit; check mode compares the received parity bit.
// - Keeps a sticky error flag and a saturating error counter, both read by the status logic.
// PARAMETERS
// - DATA_WIDTH  8  word width in bits (1..32)
// - CNT_WIDTH   8  error-counter width in bits; counter saturates at 2**CNT_WIDTH-1
// PORTS
// - clk          in   1           system clock; everything is on the rising edge
// - rst          in   1           synchronous, active-high reset
// - parity_type  in   2           00 none; 01/11 odd; 10 even; sampled on input accept
// - mode         in   1           0 generate, 1 check; sampled on input accept
// - in_valid     in   1           input word present
// - in_ready     out  1           unit can accept a word this cycle
// - data_in      in   DATA_WIDTH  input word
// - parity_in    in   1           received parity bit (check mode only)
// - out_valid    out  1           output register holds a word
// - out_ready    in   1           downstream consumes the output this cycle
// - data_out     out  DATA_WIDTH  registered copy of the accepted word
// - parity_out   out  1           computed parity bit for the held word
// - parity_err   out  1           held word failed its check (qualified by out_valid)
// - err_sticky   out  1           set by any accepted failing word; cleared by clr_err
// - err_count    out  CNT_WIDTH   count of failing words accepted, saturating
// - clr_err      in   1           clears err_sticky and err_count
// BEHAVIOUR
// - Reset: every output is 0 (out_valid, data_out, parity_out, parity_err, err_sticky, err_count).
//   in_ready is 1 one cycle after rst deasserts.
// - Accept: word is taken when in_valid && in_ready; in_ready = !out_valid || out_ready.
// - Output handshake
//   - out_valid rises the cycle after accept.
//   - Output is consumed when out_valid && out_ready.
//   - A simultaneous consume and accept loads the new word with no bubble (full throughput).
// - State machine
//   - EMPTY -> FULL on accept.
//   - FULL -> FULL on consume+accept.
//   - FULL -> EMPTY on consume without accept.
//   - FULL holds while out_ready=0: data_out, parity_out and parity_err stay stable.
// - Parity computation, p = XOR of data_in[DATA_WIDTH-1:0]:
//   - odd: parity_out = ~p
//   - even: parity_out = p
//   - none: parity_out = 0
// - Check mode: parity_err = (parity_out != parity_in) when type != none; otherwise 0.
// - Generate mode: parity_err = 0.
// - Error accounting, updated on the accept cycle of a failing word:
//   - err_sticky <= 1.
//   - err_count increments and saturates at all-ones; no wrap.
// - clr_err and a failing accept in the same cycle: the new error is recorded, giving
//   err_count=1 and err_sticky=1.
// - parity_type and mode changes take effect only on the next accepted word; the held word is unaffected.
// - rst mid-stream: the held word is dropped (out_valid=0) and the error state is cleared.
//   Words are never partially emitted.
// STRUCTURE
// - Shared package uart_pkg holds:
//   - localparams PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_ODD_ALT=2'b11
//   - MODE_GEN=1'b0, MODE_CHK=1'b1
// - One sub-module, parity_calc: combinational XOR-reduce plus type select, parametrised by DATA_WIDTH.
//   It is reused by the UART RX checker.
// - This module is the handshake register, EMPTY/FULL control and error accounting around parity_calc.
// TESTING
// - Gen, even, data_in=8'hA5, out_ready=1 -> next cycle out_valid=1, data_out=A5, parity_out=0.
// - Gen, odd, data_in=8'h07 -> parity_out=0; then data_in=8'h03 -> parity_out=1; type none -> 0.
// - Check, even, data_in=8'h01, parity_in=0 -> parity_err=1, err_sticky=1, err_count=1;
//   same word with parity_in=1 -> no change.
// - out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and output stable;
//   out_ready=1 -> back-to-back words with no bubble.
// - CNT_WIDTH=2, 5 failing words -> err_count=3 (saturated); clr_err together with a failing
//   accept -> err_count=1.
// - rst asserted while FULL -> next cycle all outputs 0, then in_ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART datapath constants: parity type encodings, parity mode
// encodings and the stream-register state type.
package uart_pkg;

    localparam logic [1:0] PAR_NONE    = 2'b00;
    localparam logic [1:0] PAR_ODD     = 2'b01;
    localparam logic [1:0] PAR_EVEN    = 2'b10;
    localparam logic [1:0] PAR_ODD_ALT = 2'b11;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stream_state_t;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity bit for one word: XOR-reduce of the data, then
// shaped by the selected parity type. The UART RX checker reuses this block.
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            parity_type,
    output logic                  parity
);

    logic xor_all;

    always_comb begin
        xor_all = ^data;
        parity  = 1'b0;
        case (parity_type)
            PAR_ODD, PAR_ODD_ALT: parity = ~xor_all;
            PAR_EVEN:             parity = xor_all;
            default:              parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/parity_stream_unit.sv
// One-deep registered parity generator/checker on a valid/ready stream,
// with a sticky error flag and a saturating error counter.
module parity_stream_unit
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            parity_type,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  parity_out,
    output logic                  parity_err,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    input  logic                  clr_err
);

    stream_state_t state;
    stream_state_t next_state;

    logic ready_en;
    logic accept;
    logic consume;
    logic calc_parity;
    logic calc_err;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data        (data_in),
        .parity_type (parity_type),
        .parity      (calc_parity)
    );

    // Failure is judged on the incoming word, so the error state updates on the accept cycle.
    assign calc_err = (mode == MODE_CHK) && (parity_type != PAR_NONE) &&
                      (calc_parity != parity_in);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // Holds input acceptance off until the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_FULL;
            ST_FULL:  if (consume && !accept) next_state = ST_EMPTY;
            default:  next_state = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_FULL);
        in_ready  = ready_en && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            parity_out <= 1'b0;
            parity_err <= 1'b0;
        end else if (accept) begin
            data_out   <= data_in;
            parity_out <= calc_parity;
            parity_err <= calc_err;
        end
    end

    // A failing accept wins over clr_err so the new error is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (accept && calc_err) begin
            err_sticky <= 1'b1;
            if (clr_err)
                err_count <= CNT_WIDTH'(1);
            else if (err_count != {CNT_WIDTH{1'b1}})
                err_count <= err_count + CNT_WIDTH'(1);
        end else if (clr_err) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end
    end

endmodule
